// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper and its bench.
package tts_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int N_VARS = 4;
  localparam int N_VEC  = 16;

  // Reference truth table of (a+c)(c+d')(a'+b)(b+d'), bit i = vector i.
  localparam logic [N_VEC-1:0] POS_TABLE = 16'hD0C4;

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Control and result bundle of the sweeper; the DUT is the slave side.
interface truth_table_sweeper_if;
  import tts_pkg::*;

  logic              start;
  logic              abort;
  logic [N_VARS-1:0] vec;
  logic              s;
  logic              busy;
  logic              done;
  logic              valid;
  logic [N_VEC-1:0]  table_out;
  logic [4:0]        ones_count;
  logic [N_VARS-1:0] first_true;
  logic              none_true;

  modport master (
    output start, abort,
    input  vec, s, busy, done, valid, table_out, ones_count, first_true, none_true
  );

  modport slave (
    input  start, abort,
    output vec, s, busy, done, valid, table_out, ones_count, first_true, none_true
  );

endinterface

// File: rtl/truth_table_sweeper_pos_eval.sv
// Combinational product-of-sums evaluator (a+c)(c+d')(a'+b)(b+d').
module pos_eval (
  output logic s,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d
);

  assign s = (a | c) & (c | ~d) & (~a | b) & (b | ~d);

endmodule

// File: rtl/truth_table_sweeper.sv
// Steps every input vector through pos_eval, holding each HOLD cycles,
// and publishes the captured truth table with popcount and lowest true vector.
module truth_table_sweeper
  import tts_pkg::*;
#(
  parameter int HOLD = 1
) (
  input logic                 clk,
  input logic                 rst,
  truth_table_sweeper_if.slave bus
);

  localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(HOLD - 1);
  localparam logic [N_VARS-1:0] LAST_VEC = N_VARS'(N_VEC - 1);

  state_e            state_q, state_d;
  logic [N_VARS-1:0] vec_q, vec_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_VEC-1:0]  shadow_q, shadow_d;
  logic [N_VEC-1:0]  table_q, table_d;
  logic [4:0]        ones_q, ones_d;
  logic [N_VARS-1:0] first_q, first_d;
  logic              none_q, none_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              s_w;
  logic              last_hold;
  logic              completing;
  logic [4:0]        pop;
  logic [N_VARS-1:0] low;

  pos_eval u_eval (
    .s (s_w),
    .a (vec_q[3]),
    .b (vec_q[2]),
    .c (vec_q[1]),
    .d (vec_q[0])
  );

  assign last_hold  = (cnt_q == LAST_CNT);
  // Abort wins over the final capture, so an aborted sweep never completes.
  assign completing = (state_q == RUN) && !bus.abort && last_hold && (vec_q == LAST_VEC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      table_q  <= '0;
      ones_q   <= '0;
      first_q  <= '0;
      none_q   <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      table_q  <= table_d;
      ones_q   <= ones_d;
      first_q  <= first_d;
      none_q   <= none_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start && !bus.abort) state_d = RUN;
      RUN: begin
        if (bus.abort)       state_d = IDLE;
        else if (completing) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    table_d  = table_q;
    ones_d   = ones_q;
    first_d  = first_q;
    none_d   = none_q;
    valid_d  = valid_q;
    pop      = '0;
    low      = '0;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          vec_d    = '0;
          cnt_d    = '0;
          shadow_d = '0;
        end
      end
      RUN: begin
        if (!bus.abort) begin
          if (last_hold) begin
            shadow_d[vec_q] = s_w;
            if (vec_q != LAST_VEC) begin
              vec_d = vec_q + 1'b1;
              cnt_d = '0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: ;
    endcase

    // shadow_d already holds the last vector's bit when the sweep completes.
    for (int i = 0; i < N_VEC; i++) pop = pop + {4'b0000, shadow_d[i]};
    for (int i = N_VEC - 1; i >= 0; i--) if (shadow_d[i]) low = N_VARS'(i);

    if (completing) begin
      table_d = shadow_d;
      ones_d  = pop;
      first_d = low;
      none_d  = (shadow_d == '0);
      valid_d = 1'b1;
    end
  end

  assign busy_d = (state_d == RUN);
  assign done_d = (state_d == DONE);

  assign bus.vec        = vec_q;
  assign bus.s          = s_w;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.valid      = valid_q;
  assign bus.table_out  = table_q;
  assign bus.ones_count = ones_q;
  assign bus.first_true = first_q;
  assign bus.none_true  = none_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: sweep starts push expected results, a negedge monitor
// pops and compares them whenever a DUT pulses done.
module tb_truth_table_sweeper;
  import tts_pkg::*;

  localparam logic [15:0] EXP_TABLE = 16'hD0C4;
  localparam int          EXP_ONES  = 6;
  localparam int          EXP_FIRST = 2;

  typedef struct {
    int          done_cyc;
    logic [15:0] tbl;
    logic [4:0]  ones;
    logic [3:0]  first;
    logic        none;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  int   done_cnt1;
  int   done_cnt3;
  exp_t q1[$];
  exp_t q3[$];

  truth_table_sweeper_if bus1 ();
  truth_table_sweeper_if bus3 ();

  truth_table_sweeper #(.HOLD(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  truth_table_sweeper #(.HOLD(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic compareResult(input string tag, input exp_t e, input int c,
                               input logic [15:0] tbl, input logic [4:0] ones,
                               input logic [3:0] first, input logic none,
                               input logic valid, input logic busy);
    checkOutput({tag, "_done_cycle"}, c, e.done_cyc);
    checkOutput({tag, "_table"}, tbl, e.tbl);
    checkOutput({tag, "_ones"}, ones, e.ones);
    checkOutput({tag, "_first"}, first, e.first);
    checkOutput({tag, "_none"}, none, e.none);
    checkOutput({tag, "_valid"}, valid, 1);
    checkOutput({tag, "_busy_in_done"}, busy, 0);
  endtask

  // Monitors: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus1.done) begin
      done_cnt1++;
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL d1_unexpected_done: got done=1, expected none (cycle %0d)", cyc);
      end else begin
        compareResult("d1", q1.pop_front(), cyc, bus1.table_out, bus1.ones_count,
                      bus1.first_true, bus1.none_true, bus1.valid, bus1.busy);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus3.done) begin
      done_cnt3++;
      if (q3.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL d3_unexpected_done: got done=1, expected none (cycle %0d)", cyc);
      end else begin
        compareResult("d3", q3.pop_front(), cyc, bus3.table_out, bus3.ones_count,
                      bus3.first_true, bus3.none_true, bus3.valid, bus3.busy);
      end
    end
  end

  // Called at a negedge; drives for exactly one sampling edge, returns that edge number.
  task automatic applyStimulus(input int which, input logic st, input logic ab,
                               input bit push, output int k);
    exp_t e;
    if (which == 1) begin
      bus1.start = st;
      bus1.abort = ab;
    end else begin
      bus3.start = st;
      bus3.abort = ab;
    end
    @(posedge clk);
    @(negedge clk);
    k = cyc;
    bus1.start = 1'b0;
    bus1.abort = 1'b0;
    bus3.start = 1'b0;
    bus3.abort = 1'b0;
    if (push) begin
      e.done_cyc = k + 16 * ((which == 1) ? 1 : 3);
      e.tbl      = EXP_TABLE;
      e.ones     = 5'(EXP_ONES);
      e.first    = 4'(EXP_FIRST);
      e.none     = 1'b0;
      if (which == 1) q1.push_back(e);
      else            q3.push_back(e);
    end
  endtask

  task automatic waitDone(input int which, input int budget);
    int n = 0;
    while (!((which == 1) ? bus1.done : bus3.done) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wait_done", (which == 1) ? bus1.done : bus3.done, 1);
  endtask

  task automatic waitVec1(input logic [3:0] target, input int budget);
    int n = 0;
    while (bus1.vec !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wait_vec", bus1.vec, target);
  endtask

  task automatic checkAllZero1(input string tag);
    checkOutput({tag, "_vec"}, bus1.vec, 0);
    checkOutput({tag, "_s"}, bus1.s, 0);
    checkOutput({tag, "_busy"}, bus1.busy, 0);
    checkOutput({tag, "_done"}, bus1.done, 0);
    checkOutput({tag, "_valid"}, bus1.valid, 0);
    checkOutput({tag, "_table"}, bus1.table_out, 0);
    checkOutput({tag, "_ones"}, bus1.ones_count, 0);
    checkOutput({tag, "_first"}, bus1.first_true, 0);
    checkOutput({tag, "_none"}, bus1.none_true, 0);
  endtask

  initial begin
    int k;
    int dummy;
    cyc        = 0;
    checks     = 0;
    errors     = 0;
    done_cnt1  = 0;
    done_cnt3  = 0;
    rst        = 1'b1;
    bus1.start = 1'b0;
    bus1.abort = 1'b0;
    bus3.start = 1'b0;
    bus3.abort = 1'b0;

    repeat (2) @(negedge clk);
    checkAllZero1("reset");
    rst = 1'b0;
    @(negedge clk);

    // HOLD=3: each vector must persist exactly three cycles.
    applyStimulus(3, 1'b1, 1'b0, 1'b1, k);
    for (int j = 0; j < 48; j++) begin
      checkOutput("h3_vec", bus3.vec, j / 3);
      checkOutput("h3_busy", bus3.busy, 1);
      @(negedge clk);
    end
    checkOutput("h3_done_now", bus3.done, 1);
    @(negedge clk);

    // HOLD=1 sweep with a stray start while busy.
    applyStimulus(1, 1'b1, 1'b0, 1'b1, k);
    checkOutput("d1_busy_after_start", bus1.busy, 1);
    checkOutput("d1_vec_after_start", bus1.vec, 0);
    repeat (4) @(negedge clk);
    applyStimulus(1, 1'b1, 1'b0, 1'b0, dummy);
    waitDone(1, 40);

    // Restart on the cycle after done; vec holds 15 until then.
    @(negedge clk);
    checkOutput("idle_vec_hold", bus1.vec, 15);
    checkOutput("idle_busy", bus1.busy, 0);
    applyStimulus(1, 1'b1, 1'b0, 1'b0, dummy);
    checkOutput("restart_busy", bus1.busy, 1);
    checkOutput("restart_vec", bus1.vec, 0);

    // Abort at vec=9: back to idle, results untouched.
    waitVec1(4'd9, 20);
    applyStimulus(1, 1'b0, 1'b1, 1'b0, dummy);
    checkOutput("abort_busy", bus1.busy, 0);
    checkOutput("abort_done", bus1.done, 0);
    checkOutput("abort_vec", bus1.vec, 9);
    checkOutput("abort_table", bus1.table_out, EXP_TABLE);
    checkOutput("abort_ones", bus1.ones_count, EXP_ONES);
    checkOutput("abort_valid", bus1.valid, 1);
    repeat (20) @(negedge clk);

    // start and abort together in IDLE stay idle.
    applyStimulus(1, 1'b1, 1'b1, 1'b0, dummy);
    for (int j = 0; j < 3; j++) begin
      checkOutput("start_abort_busy", bus1.busy, 0);
      @(negedge clk);
    end

    // Reset mid-sweep at vec=5 clears everything immediately.
    applyStimulus(1, 1'b1, 1'b0, 1'b0, dummy);
    waitVec1(4'd5, 20);
    #2 rst = 1'b1;
    #1 checkAllZero1("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(1, 1'b1, 1'b0, 1'b1, k);
    waitDone(1, 40);
    repeat (3) @(negedge clk);

    checkOutput("d1_done_count", done_cnt1, 2);
    checkOutput("d3_done_count", done_cnt3, 1);
    checkOutput("d1_queue_empty", q1.size(), 0);
    checkOutput("d3_queue_empty", q3.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
